// File: rtl/edid_update_ctrl.sv
// ============================================================================
// edid_update_ctrl : EDID RAM update sequencer, I2C read arbiter, HPD hold-off
// Optional macro EDID_CSUM_FIX_EN rewrites each block checksum byte. Rev 1.0
// ============================================================================
`default_nettype none

module edid_update_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int EDID_BYTES  = 256,
  parameter int HPD_LOW_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_req,
  output logic              upd_busy,
  output logic              upd_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  input  logic              i2c_rd_req,
  input  logic [ADDR_W-1:0] i2c_rd_addr,
  output logic              i2c_rd_vld,
  output logic [7:0]        i2c_rd_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              hpd,
  output logic              csum_err
);

  localparam int LOW_W = (HPD_LOW_CYC < 1) ? 1 : $clog2(HPD_LOW_CYC + 1);
  localparam logic [LOW_W-1:0]  LOW_MAX   = LOW_W'(HPD_LOW_CYC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(EDID_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic              hpd_q, hpd_d;
  logic              csum_err_q, csum_err_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              wr_fire;
  logic [6:0]        blk_off;
  logic [7:0]        acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      low_cnt_q  <= '0;
      acc_q      <= '0;
      hpd_q      <= 1'b0;
      csum_err_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      low_cnt_q  <= low_cnt_d;
      acc_q      <= acc_d;
      hpd_q      <= hpd_d;
      csum_err_q <= csum_err_d;
      rd_pend_q  <= rd_pend_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    low_cnt_d  = low_cnt_q;
    acc_d      = acc_q;
    hpd_d      = hpd_q;
    csum_err_d = csum_err_q;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    blk_off  = byte_cnt_q[6:0];
    acc_sum  = acc_q + wr_data;
    wr_ready = (state_q == ST_LOAD) && !i2c_rd_req;
    wr_fire  = wr_valid && wr_ready;

    // RAM read data lands one cycle after the request and is registered once more.
    rd_pend_d = i2c_rd_req;
    rd_vld_d  = rd_pend_q;
    rd_data_d = rd_pend_q ? ram_rdata : rd_data_q;

    if (i2c_rd_req) begin
      ram_ce   = 1'b1;
      ram_addr = i2c_rd_addr;
    end else if (wr_fire) begin
      ram_ce    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = byte_cnt_q;
`ifdef EDID_CSUM_FIX_EN
      ram_wdata = (blk_off == 7'd127) ? (8'd0 - acc_q) : wr_data;
`else
      ram_wdata = wr_data;
`endif
    end

    if (((state_q == ST_LOAD) || (state_q == ST_HOLD)) && (low_cnt_q != LOW_MAX)) begin
      low_cnt_d = low_cnt_q + LOW_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (upd_req) begin
          state_d    = ST_LOAD;
          hpd_d      = 1'b0;
          byte_cnt_d = '0;
          low_cnt_d  = '0;
          acc_d      = '0;
          csum_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (wr_fire) begin
          byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          // Offset 0 restarts the block sum; offset 127 is the checksum byte itself.
          if (blk_off == 7'd0) begin
            acc_d = wr_data;
          end else if (blk_off != 7'd127) begin
            acc_d = acc_sum;
          end
`ifndef EDID_CSUM_FIX_EN
          if ((blk_off == 7'd127) && (acc_sum != 8'd0)) begin
            csum_err_d = 1'b1;
          end
`endif
          if (byte_cnt_q == LAST_ADDR) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (low_cnt_q >= LOW_MAX) begin
          state_d = ST_DONE;
          hpd_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign upd_busy    = (state_q != ST_IDLE);
  assign upd_done    = (state_q == ST_DONE);
  assign hpd         = hpd_q;
  assign csum_err    = csum_err_q;
  assign i2c_rd_vld  = rd_vld_q;
  assign i2c_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_edid_update_ctrl.sv
// ============================================================================
// tb_edid_update_ctrl : scoreboard bench for edid_update_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_edid_update_ctrl;

  localparam int ADDR_W = 8;
  localparam int NB     = 256;
  localparam int LOW_S  = 64;
  localparam int LOW_L  = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              upd_req = 1'b0;
  logic              wr_valid = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              i2c_rd_req = 1'b0;
  logic [ADDR_W-1:0] i2c_rd_addr = '0;
  logic              upd_busy, upd_done, wr_ready, i2c_rd_vld;
  logic              ram_ce, ram_we, hpd, csum_err;
  logic [7:0]        i2c_rd_data, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata = 8'h00;

  logic              l_busy, l_done, l_wr_ready, l_rd_vld, l_ce, l_we, hpd_l, l_csum_err;
  logic [7:0]        l_rd_data, l_wdata;
  logic [ADDR_W-1:0] l_addr;

  edid_update_ctrl #(.ADDR_W(ADDR_W), .EDID_BYTES(NB), .HPD_LOW_CYC(LOW_S)) dut (
    .clk(clk), .rst_n(rst_n), .upd_req(upd_req), .upd_busy(upd_busy), .upd_done(upd_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .i2c_rd_req(i2c_rd_req), .i2c_rd_addr(i2c_rd_addr), .i2c_rd_vld(i2c_rd_vld),
    .i2c_rd_data(i2c_rd_data), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .hpd(hpd), .csum_err(csum_err)
  );

  // Second instance with a long HPD-low time; only its hpd timing is observed.
  edid_update_ctrl #(.ADDR_W(ADDR_W), .EDID_BYTES(NB), .HPD_LOW_CYC(LOW_L)) dut_long (
    .clk(clk), .rst_n(rst_n), .upd_req(upd_req), .upd_busy(l_busy), .upd_done(l_done),
    .wr_valid(wr_valid), .wr_ready(l_wr_ready), .wr_data(wr_data),
    .i2c_rd_req(i2c_rd_req), .i2c_rd_addr(i2c_rd_addr), .i2c_rd_vld(l_rd_vld),
    .i2c_rd_data(l_rd_data), .ram_ce(l_ce), .ram_we(l_we), .ram_addr(l_addr),
    .ram_wdata(l_wdata), .ram_rdata(8'h00), .hpd(hpd_l), .csum_err(l_csum_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [NB];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct { logic [7:0] data; int due; } rd_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  logic hpd_prev = 1'b0, hpd_l_prev = 1'b0;
  int   rise_s = -1, rise_l = -1, done_cnt = 0;

  always @(negedge clk) begin
    if (ram_ce && ram_we) begin
      if (wr_q.size() == 0) chk("wr_q_nonempty", 32'(wr_q.size()), 1);
      else begin
        we = wr_q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(we.addr));
        chk("wr_data", 32'(ram_wdata), 32'(we.data));
      end
    end
    if (i2c_rd_vld) begin
      if (rd_q.size() == 0) chk("rd_q_nonempty", 32'(rd_q.size()), 1);
      else begin
        re = rd_q.pop_front();
        chk("rd_data", 32'(i2c_rd_data), 32'(re.data));
        chk("rd_latency", cyc, re.due);
      end
    end
    if (hpd && !hpd_prev) begin
      rise_s = cyc;
      chk("done_with_hpd", 32'(upd_done), 1);
    end
    if (upd_done) done_cnt++;
    if (hpd_l && !hpd_l_prev) rise_l = cyc;
    hpd_prev   = hpd;
    hpd_l_prev = hpd_l;
  end

  logic [7:0] host_img [NB];
  logic [7:0] exp_img  [NB];
  int         load_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds a two-block image; with bad=1, block 0 bytes 0..126 sum to 0x37 and byte 127 is 0x00.
  task automatic build_img(input bit bad);
    int i;
    logic [7:0] s, v;
    for (int b = 0; b < NB / 128; b++) begin
      s = 8'h00;
      for (int o = 0; o < 126; o++) begin
        i = b * 128 + o;
        v = 8'(i * 7 + 3) ^ 8'(b * 29 + (bad ? 5 : 0));
        host_img[i] = v;
        s = s + v;
      end
      i = b * 128 + 126;
      v = (bad && b == 0) ? (8'h37 - s) : 8'(i * 13 + 1);
      host_img[i] = v;
      s = s + v;
      host_img[b * 128 + 127] = (bad && b == 0) ? 8'h00 : (8'h00 - s);
    end
    for (int k = 0; k < NB; k++) exp_img[k] = host_img[k];
`ifdef EDID_CSUM_FIX_EN
    if (bad) exp_img[127] = 8'hC9;
`endif
  endtask

  task automatic start_upd();
    rise_s  = -1;
    upd_req = 1'b1;
    tick();
    upd_req  = 1'b0;
    load_cyc = cyc;
    #1;
    chk("hpd_low_at_load", 32'(hpd), 0);
    chk("busy_at_load", 32'(upd_busy), 1);
  endtask

  task automatic send_bytes(input int n, input int coll);
    logic fired;
    int   guard;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = host_img[i];
      wr_q.push_back('{addr: ADDR_W'(i), data: exp_img[i]});
      fired = 1'b0;
      guard = 0;
      while (!fired && guard < 8) begin
        if (i == coll && guard == 0) begin
          i2c_rd_req  = 1'b1;
          i2c_rd_addr = ADDR_W'(16);
          rd_q.push_back('{data: exp_img[16], due: cyc + 2});
        end else begin
          i2c_rd_req = 1'b0;
        end
        @(negedge clk);
        if (i == coll && guard == 0) chk("coll_wr_ready", 32'(wr_ready), 0);
        fired = wr_ready;
        tick();
        guard++;
      end
      if (!fired) chk("wr_accept", 32'(fired), 1);
    end
    wr_valid   = 1'b0;
    i2c_rd_req = 1'b0;
  endtask

  task automatic wait_done(input int exp_rise, input string tag);
    int g = 0;
    while (upd_busy && g < 3000) begin
      tick();
      g++;
    end
    chk(tag, rise_s, exp_rise);
  endtask

  task automatic readback();
    for (int a = 0; a < NB; a++) begin
      i2c_rd_req  = 1'b1;
      i2c_rd_addr = ADDR_W'(a);
      rd_q.push_back('{data: exp_img[a], due: cyc + 2});
      tick();
    end
    i2c_rd_req = 1'b0;
    repeat (3) tick();
    chk("rd_q_drained", 32'(rd_q.size()), 0);
  endtask

  int l1, g;

  initial begin
    repeat (3) tick();
    chk("rst_hpd", 32'(hpd), 0);
    chk("rst_busy", 32'(upd_busy), 0);
    chk("rst_done", 32'(upd_done), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_vld", 32'(i2c_rd_vld), 0);
    chk("rst_rd_data", 32'(i2c_rd_data), 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_csum_err", 32'(csum_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("hpd_before_first_update", 32'(hpd), 0);

    // Full load at one byte per cycle; upd_req pulsed while in HOLD must be dropped.
    build_img(1'b0);
    start_upd();
    l1 = load_cyc;
    send_bytes(NB, -1);
    chk("busy_in_hold", 32'(upd_busy), 1);
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    wait_done(l1 + 257, "hpd_rise_short");
    g = 0;
    while (rise_l < 0 && g < 1500) begin
      tick();
      g++;
    end
    chk("hpd_rise_long", rise_l, l1 + 1001);
    chk("csum_err_valid_img", 32'(csum_err), 0);
    chk("hpd_high_idle", 32'(hpd), 1);
    readback();

    // Collision: I2C read of 0x10 at the same cycle the host offers byte 50.
    start_upd();
    send_bytes(NB, 50);
    wait_done(load_cyc + 258, "hpd_rise_coll");

    // Partial image abandoned by an asynchronous reset mid-cycle.
    start_upd();
    send_bytes(100, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(upd_busy), 0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 0);
    chk("mid_rst_rd_data", 32'(i2c_rd_data), 0);
    chk("mid_rst_hpd", 32'(hpd), 0);
    chk("mid_rst_wr_q", 32'(wr_q.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fresh update from address 0 with a bad block-0 checksum.
    build_img(1'b1);
    start_upd();
    send_bytes(NB, -1);
    wait_done(load_cyc + 257, "hpd_rise_after_rst");
`ifdef EDID_CSUM_FIX_EN
    chk("csum_err_bad_img", 32'(csum_err), 0);
`else
    chk("csum_err_bad_img", 32'(csum_err), 1);
`endif
    readback();
    chk("done_pulses", done_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/edid_update_ctrl.md
# edid_update_ctrl

Sequencer and arbiter for the shared EDID RAM behind the I2C EDID PROM slave. It lets a host stream a new EDID image into the single-port RAM and holds hot-plug detect (HPD) low for a guaranteed minimum time around the update. It services I2C-side byte reads with priority over host writes at all times. Each 128-byte EDID block checksum is either checked or repaired, depending on configuration.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM address width.
- `EDID_BYTES`, default 256: image size. Must be a multiple of 128 and ≤ 2^`ADDR_W`.
- `HPD_LOW_CYC`, default 100000: minimum HPD-low time in `clk` cycles, counted from LOAD entry.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `upd_req` in 1: one-cycle request to start an update. Ignored unless the FSM is in IDLE.
- `upd_busy` out 1: high in every state except IDLE.
- `upd_done` out 1: one-cycle pulse at update completion.
- `wr_valid` in 1: host write byte is valid.
- `wr_ready` out 1: block accepts the host write byte this cycle.
- `wr_data` in 8: host write byte.
- `i2c_rd_req` in 1: one-cycle read request from the I2C slave.
- `i2c_rd_addr` in `ADDR_W`: I2C read address.
- `i2c_rd_vld` out 1: one-cycle pulse, read data is valid.
- `i2c_rd_data` out 8: read data, held until the next read.
- `ram_ce` out 1: RAM chip enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out `ADDR_W`: RAM address.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data, registered one cycle after `ram_ce`.
- `hpd` out 1: hot-plug detect to the sink connector.
- `csum_err` out 1: sticky checksum-error flag.

## Operation
- FSM states: IDLE, LOAD, HOLD, DONE.
- Reset values: FSM in IDLE, `hpd`=0, `upd_busy`=0, `upd_done`=0, `wr_ready`=0, `i2c_rd_vld`=0, `i2c_rd_data`=0, `ram_ce`=0, `ram_we`=0, `csum_err`=0. All counters are 0.
- `hpd` stays 0 after reset until the first update completes, because RAM contents are undefined until then.
- IDLE to LOAD on `upd_req`. On the next cycle: `hpd`=0, `byte_cnt`=0, `low_cnt`=0, block checksum accumulator=0, `csum_err` cleared.
- LOAD:
  - `wr_ready` = 1 when `i2c_rd_req` is 0.
  - On each `wr_valid && wr_ready`: write the byte to RAM at `byte_cnt`, then increment `byte_cnt`.
  - After byte `EDID_BYTES-1` is written, go to HOLD.
- HOLD: stay until `low_cnt` ≥ `HPD_LOW_CYC`, then go to DONE.
- DONE lasts one cycle: `hpd`=1 and `upd_done`=1, then return to IDLE. `hpd` stays 1 until the next LOAD.
- `low_cnt` increments every cycle in LOAD and HOLD and saturates at `HPD_LOW_CYC`.
- Arbitration: an `i2c_rd_req` always wins the RAM, in every state. The same cycle drives `ram_ce`=1, `ram_we`=0, `ram_addr`=`i2c_rd_addr`. In that cycle `wr_ready`=0 and no host byte is consumed.
- Checksum:
  - The accumulator is 8-bit modulo sum of bytes 0..126 of the current 128-byte block.
  - It resets to 0 at every block boundary (`byte_cnt[6:0]`==0).
  - Byte 127 of each block is the checksum byte; its handling is set by Configuration.
- `upd_req` outside IDLE is dropped, with no queueing.
- `wr_valid` outside LOAD is ignored; `wr_ready` is 0 there.

## Timing
- I2C read latency: `i2c_rd_req` in cycle N gives `ram_rdata` in N+1, captured into `i2c_rd_data`. `i2c_rd_vld`=1 in cycle N+2.
- Back-to-back I2C reads every cycle are supported, at full throughput.
- Host write: a byte is accepted and written in the same cycle (`ram_we`=1) when the handshake fires. Peak rate is 1 byte per cycle.
- LOAD entry is 1 cycle after `upd_req`; `hpd` falls in that cycle.
- Minimum HPD-low time: `hpd` rises exactly max(`HPD_LOW_CYC`, load time)+1 cycles after LOAD entry (HOLD exit plus the DONE cycle).
- `upd_done` is coincident with the rising edge of `hpd`.
- Reset asserted mid-operation takes effect immediately (asynchronous). All outputs go to their reset values and any partial image is abandoned. The next update restarts at address 0.

## Configuration
- `EDID_CSUM_FIX_EN` defined:
  - The host byte at each block offset 127 is discarded.
  - `ram_wdata` = (0 − accumulator) mod 256, so every block sums to 0.
  - `csum_err` stays 0.
- Not defined:
  - The host byte is written unchanged.
  - If (accumulator + byte) mod 256 ≠ 0, `csum_err` is set. It stays set until the next accepted `upd_req`.

## Test plan
- Reset: apply `rst_n`=0 -> every output at its listed reset value; `hpd`=0 until the first DONE.
- Full load, `HPD_LOW_CYC`=64, 256 valid-checksum bytes at 1 byte/cycle:
  - `hpd`=0 from the cycle after `upd_req`.
  - `hpd` and `upd_done` go to 1 together 257 cycles after LOAD entry.
  - An I2C readback of 0..255 matches the image.
- Collision: `i2c_rd_req` at addr 0x10 in the same cycle as `wr_valid`:
  - `wr_ready`=0 that cycle.
  - `i2c_rd_vld` 2 cycles later with the stored byte.
  - The host byte is accepted the next cycle at the correct address; no gaps or duplicates.
- Checksum: block-0 bytes 0..126 sum to 0x37 and host byte 127=0x00:
  - Macro off: RAM[127]=0x00 and `csum_err`=1.
  - Macro on: RAM[127]=0xC9 and `csum_err`=0.
- Minimum low time: `HPD_LOW_CYC`=1000 with a 256-cycle load -> FSM sits in HOLD; `hpd` rises at cycle 1001 after LOAD entry.
- Reset and ignore:
  - `rst_n` pulsed after 100 bytes -> reset values immediately.
  - A new update writes from address 0.
  - `upd_req` during HOLD has no effect.
